// File: rtl/g_2arb1_if.sv
// g_2arb1_if: request/grant bundle between requesters, resource and arbiter.
// Mixed polarity: AN and GA_N are active-low, the rest active-high.
interface g_2arb1_if;
  logic AN;
  logic B;
  logic DONE;
  logic GA_N;
  logic GB;
  logic BUSY;
  logic TOUT;

  modport master (
    output AN, B, DONE,
    input  GA_N, GB, BUSY, TOUT
  );

  modport slave (
    input  AN, B, DONE,
    output GA_N, GB, BUSY, TOUT
  );
endinterface

// File: rtl/g_2arb1.sv
// g_2arb1: two-requester round-robin arbiter, A active-low, B active-high.
// Registered, exclusive grants with a hold timeout and a forced release gap.
module g_2arb1 #(
  parameter int MAX_HOLD = 16,
  parameter int GAP      = 1
) (
  input logic      CK,
  input logic      CD,
  g_2arb1_if.slave arb
);
  localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);
  localparam logic [1:0] GAP_LAST = 2'(GAP - 1);
  localparam bit TMO_EN = (MAX_HOLD != 0);

  typedef enum logic [1:0] {
    S_IDLE,
    S_GNT_A,
    S_GNT_B,
    S_GAP
  } state_t;

  state_t        state_q, state_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [1:0]    gcnt_q, gcnt_d;
  logic          last_b_q, last_b_d;
  logic          ga_n_q, ga_n_d;
  logic          gb_q, gb_d;
  logic          busy_q, busy_d;
  logic          tout_q, tout_d;

  logic req_a, req_b;
  logic pick_a, pick_b;
  logic own_a, own_req;
  logic tmo, eval;

  assign req_a = ~arb.AN;
  assign req_b = arb.B;

  // On a tie the side not served last wins
  assign pick_a = req_a & (~req_b | last_b_q);
  assign pick_b = req_b & ~pick_a;

  assign own_a   = (state_q == S_GNT_A);
  assign own_req = own_a ? req_a : req_b;
  assign tmo     = TMO_EN && (hold_q == HOLD_LAST);

  // Final gap cycle arbitrates like IDLE so the gap is exactly GAP long
  assign eval = (state_q == S_IDLE) ||
                ((state_q == S_GAP) && (gcnt_q == GAP_LAST));

  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    gcnt_d   = gcnt_q;
    last_b_d = last_b_q;
    ga_n_d   = 1'b1;
    gb_d     = 1'b0;
    busy_d   = 1'b0;
    tout_d   = 1'b0;
    unique case (state_q)
      S_GNT_A, S_GNT_B: begin
        if (arb.DONE || !own_req || tmo) begin
          state_d  = S_GAP;
          gcnt_d   = '0;
          hold_d   = '0;
          last_b_d = ~own_a;
          tout_d   = tmo && !arb.DONE && own_req;
        end else begin
          hold_d = TMO_EN ? hold_q + 1'b1 : '0;
          ga_n_d = ~own_a;
          gb_d   = ~own_a;
          busy_d = 1'b1;
        end
      end
      S_GAP: begin
        if (gcnt_q != GAP_LAST)
          gcnt_d = gcnt_q + 2'd1;
      end
      default: ;
    endcase
    if (eval) begin
      state_d = S_IDLE;
      gcnt_d  = '0;
      hold_d  = '0;
      if (pick_a) begin
        state_d = S_GNT_A;
        ga_n_d  = 1'b0;
        busy_d  = 1'b1;
      end else if (pick_b) begin
        state_d = S_GNT_B;
        gb_d    = 1'b1;
        busy_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge CK or posedge CD) begin
    if (CD) begin
      state_q  <= S_IDLE;
      hold_q   <= '0;
      gcnt_q   <= '0;
      last_b_q <= 1'b1;
      ga_n_q   <= 1'b1;
      gb_q     <= 1'b0;
      busy_q   <= 1'b0;
      tout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      hold_q   <= hold_d;
      gcnt_q   <= gcnt_d;
      last_b_q <= last_b_d;
      ga_n_q   <= ga_n_d;
      gb_q     <= gb_d;
      busy_q   <= busy_d;
      tout_q   <= tout_d;
    end
  end

  assign arb.GA_N = ga_n_q;
  assign arb.GB   = gb_q;
  assign arb.BUSY = busy_q;
  assign arb.TOUT = tout_q;
endmodule
